// File: rtl/pc_fetch_ctrl_pkg.sv
// pc_fetch_ctrl_pkg: shared types for the fetch controller.
// Holds the FSM state enum, the 3-bit branch condition codes, the flag bit
// positions inside F = {Z,V,N} and the condition evaluation helper.
package pc_fetch_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_ISSUE = 2'd1,
      ST_HALT  = 2'd2
   } state_e;

   localparam logic [2:0] CC_NE = 3'd0;
   localparam logic [2:0] CC_EQ = 3'd1;
   localparam logic [2:0] CC_GT = 3'd2;
   localparam logic [2:0] CC_LT = 3'd3;
   localparam logic [2:0] CC_GE = 3'd4;
   localparam logic [2:0] CC_LE = 3'd5;
   localparam logic [2:0] CC_OV = 3'd6;
   localparam logic [2:0] CC_AL = 3'd7;

   localparam int FLAG_Z = 2;
   localparam int FLAG_V = 1;
   localparam int FLAG_N = 0;

   // Evaluates a branch condition code against a {Z,V,N} flag vector.
   function automatic logic cond_true(input logic [2:0] cc, input logic [2:0] f);
      logic z;
      logic v;
      logic n;
      z = f[FLAG_Z];
      v = f[FLAG_V];
      n = f[FLAG_N];
      case (cc)
         CC_NE:   cond_true = ~z;
         CC_EQ:   cond_true = z;
         CC_GT:   cond_true = ~z & ~n;
         CC_LT:   cond_true = n;
         CC_GE:   cond_true = z | ~n;
         CC_LE:   cond_true = z | n;
         CC_OV:   cond_true = v;
         CC_AL:   cond_true = 1'b1;
         default: cond_true = 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// pc_fetch_ctrl_if: instruction-memory, decode and flag signals of the fetch
// controller. master = the controller, slave = its environment.
interface pc_fetch_ctrl_if;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_ack;
   logic [15:0] imem_rdata;
   logic        inst_valid;
   logic [15:0] inst;
   logic [15:0] inst_pc;
   logic        inst_ready;
   logic [15:0] rs_data;
   logic [2:0]  flag_we;
   logic [2:0]  flag_in;
   logic [2:0]  flags;
   logic        halted;

   modport master (
      output imem_req, imem_addr, inst_valid, inst, inst_pc, flags, halted,
      input  imem_ack, imem_rdata, inst_ready, rs_data, flag_we, flag_in
   );

   modport slave (
      input  imem_req, imem_addr, inst_valid, inst, inst_pc, flags, halted,
      output imem_ack, imem_rdata, inst_ready, rs_data, flag_we, flag_in
   );
endinterface

// File: rtl/pc_next_calc.sv
// pc_next_calc: combinational next-PC for an issued, non-HLT instruction.
// B takes pc+2+(sext(imm9)<<1), BR takes rs_data, both only when the condition
// holds on the supplied flags; everything else falls through to pc+2.
// All sums wrap modulo 2^16.
module pc_next_calc
   import pc_fetch_ctrl_pkg::*;
#(
   parameter logic [3:0] B_OPCODE  = 4'hC,
   parameter logic [3:0] BR_OPCODE = 4'hD
) (
   input  logic [15:0] pc,
   input  logic [15:0] inst,
   input  logic [15:0] rs_data,
   input  logic [2:0]  flags,
   output logic [15:0] next_pc
);

   logic [15:0] seq_pc_s;
   logic [15:0] br_off_s;
   logic [15:0] b_target_s;
   logic        taken_s;

   // Compute fall-through and branch targets, then pick one by opcode and condition.
   always_comb begin
      seq_pc_s   = pc + 16'd2;
      br_off_s   = {{6{inst[8]}}, inst[8:0], 1'b0};
      b_target_s = seq_pc_s + br_off_s;
      taken_s    = cond_true(inst[11:9], flags);
      next_pc    = seq_pc_s;
      if ((inst[15:12] == B_OPCODE) && taken_s) begin
         next_pc = b_target_s;
      end else if ((inst[15:12] == BR_OPCODE) && taken_s) begin
         next_pc = rs_data;
      end else begin
         next_pc = seq_pc_s;
      end
   end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: owns the PC and the {Z,V,N} flag register and sequences
// single-outstanding instruction fetch: FETCH -> ISSUE -> FETCH, or HALT on HLT.
// Branches resolve when decode accepts the held word, so a redirect adds no cycle.
// Build option FLAG_BYPASS_EN: branch conditions see same-cycle flag writes
// (flag_in on bits with flag_we set); without it they see registered F only.
module pc_fetch_ctrl
   import pc_fetch_ctrl_pkg::*;
#(
   parameter logic [15:0] RESET_PC   = 16'h0000,
   parameter logic [3:0]  B_OPCODE   = 4'hC,
   parameter logic [3:0]  BR_OPCODE  = 4'hD,
   parameter logic [3:0]  HLT_OPCODE = 4'hF
) (
   input  logic             clk,
   input  logic             rst_n,
   pc_fetch_ctrl_if.master  bus
);

   state_e      state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic [15:0] inst_q, inst_d;
   logic [15:0] inst_pc_q, inst_pc_d;
   logic [2:0]  flags_q, flags_d;
   logic [2:0]  cond_flags_s;
   logic [15:0] next_pc_s;

`ifdef FLAG_BYPASS_EN
   assign cond_flags_s = (bus.flag_in & bus.flag_we) | (flags_q & ~bus.flag_we);
`else
   assign cond_flags_s = flags_q;
`endif

   pc_next_calc #(
      .B_OPCODE  (B_OPCODE),
      .BR_OPCODE (BR_OPCODE)
   ) u_pc_next_calc (
      .pc      (pc_q),
      .inst    (inst_q),
      .rs_data (bus.rs_data),
      .flags   (cond_flags_s),
      .next_pc (next_pc_s)
   );

   // Next-state, PC, held-instruction and flag update logic.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      inst_d    = inst_q;
      inst_pc_d = inst_pc_q;
      flags_d   = (bus.flag_in & bus.flag_we) | (flags_q & ~bus.flag_we);
      case (state_q)
         ST_FETCH: begin
            if (bus.imem_ack) begin
               inst_d    = bus.imem_rdata;
               inst_pc_d = pc_q;
               state_d   = ST_ISSUE;
            end else begin
               state_d   = ST_FETCH;
            end
         end
         ST_ISSUE: begin
            if (bus.inst_ready) begin
               if (inst_q[15:12] == HLT_OPCODE) begin
                  state_d = ST_HALT;
               end else begin
                  pc_d    = next_pc_s;
                  state_d = ST_FETCH;
               end
            end else begin
               state_d = ST_ISSUE;
            end
         end
         ST_HALT: begin
            state_d = ST_HALT;
         end
         default: begin
            state_d = ST_HALT;
         end
      endcase
   end

   // State, PC, held instruction and flag registers; async reset abandons any fetch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_FETCH;
         pc_q      <= RESET_PC;
         inst_q    <= 16'h0000;
         inst_pc_q <= 16'h0000;
         flags_q   <= 3'b000;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         inst_q    <= inst_d;
         inst_pc_q <= inst_pc_d;
         flags_q   <= flags_d;
      end
   end

   // Outputs decode straight from registers; the request is masked while reset is held.
   assign bus.imem_req   = rst_n & (state_q == ST_FETCH);
   assign bus.imem_addr  = pc_q;
   assign bus.inst_valid = (state_q == ST_ISSUE);
   assign bus.inst       = inst_q;
   assign bus.inst_pc    = inst_pc_q;
   assign bus.flags      = flags_q;
   assign bus.halted     = (state_q == ST_HALT);

endmodule
